// File: rtl/mux_pkg.sv
// mux_pkg: shared state encoding and default widths for the mux select controller.
package mux_pkg;
    typedef enum logic [1:0] {MS_INIT, MS_RUN, MS_SETTLE, MS_HOLD_RST} ms_state_t;
    localparam int SEL_BITS_DEF   = 5;
    localparam int INPUT_BITS_DEF = 8;
    function automatic int max_int(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/mux_sel_ctrl_if.sv
// mux_sel_ctrl_if: pad-side pins and conditioned outputs toward the mux/design array.
interface mux_sel_ctrl_if #(
    parameter int SEL_BITS   = mux_pkg::SEL_BITS_DEF,
    parameter int INPUT_BITS = mux_pkg::INPUT_BITS_DEF
);
    logic [SEL_BITS-1:0]   sel_i;
    logic [INPUT_BITS-1:0] in_i;
    logic [SEL_BITS-1:0]   sel_o;
    logic [INPUT_BITS-1:0] in_o;
    logic                  rst_n_o;
    logic                  busy_o;
    modport master (output sel_i, in_i, input sel_o, in_o, rst_n_o, busy_o);
    modport slave  (input sel_i, in_i, output sel_o, in_o, rst_n_o, busy_o);
endinterface

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for asynchronous pin buses.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;
    always_ff @(posedge clk or posedge rst)
        if (rst) {q, meta} <= '0;
        else     {q, meta} <= {meta, d};
endmodule

// File: rtl/mux_sel_ctrl.sv
// mux_sel_ctrl: debounces design-select pins, commits them, then pulses the designs' reset.
module mux_sel_ctrl
    import mux_pkg::*;
#(
    parameter int SEL_BITS      = SEL_BITS_DEF,
    parameter int INPUT_BITS    = INPUT_BITS_DEF,
    parameter int SETTLE_CYCLES = 16,
    parameter int RST_CYCLES    = 4
) (
    input logic            wb_clk_i,
    input logic            wb_rst_i,
    mux_sel_ctrl_if.slave  bus
);
    localparam int CW = $clog2(max_int(SETTLE_CYCLES, RST_CYCLES)) + 1;
    ms_state_t             state, nxt;
    logic [SEL_BITS-1:0]   sel_sync, cand;
    logic [INPUT_BITS-1:0] in_sync;
    logic [CW-1:0]         cnt;
    logic                  chg, stable, done, hold_done, live;
    sync2 #(.W(SEL_BITS))   u_sel_sync (.clk(wb_clk_i), .rst(wb_rst_i), .d(bus.sel_i), .q(sel_sync));
    sync2 #(.W(INPUT_BITS)) u_in_sync  (.clk(wb_clk_i), .rst(wb_rst_i), .d(bus.in_i),  .q(in_sync));
    always_comb begin
        chg       = sel_sync != bus.sel_o;
        stable    = sel_sync == cand;
        done      = stable && cnt == CW'(SETTLE_CYCLES - 1);
        hold_done = cnt == CW'(RST_CYCLES - 1);
        nxt = state == MS_INIT   ? (done ? MS_HOLD_RST : MS_INIT)
            : state == MS_RUN    ? (chg ? MS_SETTLE : MS_RUN)
            : state == MS_SETTLE ? (!chg ? MS_RUN : done ? MS_HOLD_RST : MS_SETTLE)
            :                      (hold_done ? MS_RUN : MS_HOLD_RST);
        live = nxt == MS_RUN || nxt == MS_SETTLE;
    end
    // Outputs are registered from the next state so sel_o and the reset pulse move together.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= MS_INIT;
            cand        <= '0;
            cnt         <= '0;
            bus.sel_o   <= '0;
            bus.in_o    <= '0;
            bus.rst_n_o <= 1'b0;
            bus.busy_o  <= 1'b1;
        end else begin
            state       <= nxt;
            bus.rst_n_o <= live;
            bus.in_o    <= live ? in_sync : '0;
            bus.busy_o  <= nxt != MS_RUN;
            case (state)
                MS_INIT: begin
                    cand <= sel_sync;
                    cnt  <= (!stable || done) ? '0 : cnt + CW'(1);
                    if (done) bus.sel_o <= cand;
                end
                MS_RUN: if (chg) begin
                    cand <= sel_sync;
                    cnt  <= '0;
                end
                MS_SETTLE: if (chg) begin
                    if (!stable) cand <= sel_sync;
                    if (done) bus.sel_o <= cand;
                    cnt <= (!stable || done) ? '0 : cnt + CW'(1);
                end
                default: cnt <= cnt + CW'(1);
            endcase
        end
    end
endmodule
